lsu_data_mem: RTL and testbench
===============================

# lsu_data_mem

Parametrised, byte-addressable, little-endian data memory for the load/store unit of the out-of-order core. It supports byte, half-word and word accesses with sign or zero extension, and detects misaligned and illegal-size accesses. Every accepted request returns exactly one tagged response after a fixed, configurable latency. On reset it zeroes its contents one word per cycle before it accepts requests.

## Interface
- DEPTH_BYTES, 32: memory size in bytes; power of 2, ≥8. AW = log2(DEPTH_BYTES).
- RD_LAT, 1: request-to-response latency in cycles, 1..4.
- TAG_W, 4: width of the load/store-queue tag carried to the response.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in READY state.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  32  byte address; only [AW-1:0] is used, upper bits ignored (wrap).
- req_wdata  in  32  store data, low-order bytes used per size.
- req_tag  in  TAG_W  returned unchanged on resp_tag.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size access.
- resp_tag  out  TAG_W  tag of the responding request.
- init_done  out  1  equals req_ready.

## Operation
- FSM states: CLEAR, READY. An edge with reset high sets state=CLEAR, clear counter=0, all pipeline valid bits=0.
- CLEAR: each edge with reset low writes 0 to word cnt (bytes 4·cnt..4·cnt+3) and increments cnt. The edge that clears word DEPTH_BYTES/4−1 moves the state to READY.
- Reset during CLEAR restarts clearing from word 0.
- Accept = req_valid & req_ready. Requests presented while not ready are ignored and produce no response.
- Error check, evaluated at acceptance:
  - req_size=11 → error.
  - Half access with addr[0]=1 → error.
  - Word access with addr[1:0]≠0 → error.
  - An erroring store writes nothing. Any erroring request returns rdata=0, err=1.
- Store, little-endian: byte writes mem[a]=wdata[7:0]. Half also writes mem[a+1]=wdata[15:8]. Word also writes a+2=wdata[23:16] and a+3=wdata[31:24]. Address arithmetic is modulo DEPTH_BYTES.
- Load: reads bytes the same way.
  - Byte: bit 7 extended (sign or zero per req_unsigned).
  - Half: bit 15 extended.
  - Word: returned unchanged; req_unsigned is ignored.
- Stores respond with rdata=0, err=0 (or err=1 on error), carrying their tag.
- Only one request per cycle is possible, so there are no read/write port conflicts.

## Timing
- Reset values: req_ready=0, init_done=0, resp_valid=0, resp_err=0, resp_rdata=0, resp_tag=0.
- After reset deasserts, req_ready rises after DEPTH_BYTES/4 edges (8 edges for a depth of 32).
- Request accepted at edge N:
  - A store's memory update is visible from edge N.
  - Load data is sampled from memory at edge N.
  - resp_valid is high during the cycle following edge N+RD_LAT−1 (RD_LAT=1: the cycle right after acceptance).
- Throughput: 1 request per cycle. Responses arrive in order, one per accepted request, back-to-back.
- A store accepted at edge N followed by a load to the same address at edge N+1 returns the new data.
- Reset asserted mid-operation discards all in-flight responses. resp_valid is 0 from the next edge.

## Test plan
- Reset, DEPTH_BYTES=32 → req_ready stays 0 for 8 edges, then 1. A load of word 0x1C returns 0x00000000 with err=0.
- Store word 0xDEADBEEF @0x4 (tag 3), then load byte @0x5 signed and unsigned:
  - Signed → 0xFFFFFFBE.
  - Unsigned → 0x000000BE.
  - Half @0x6 signed → 0xFFFFDEAD.
  - The store response returns tag 3.
- Misalignment:
  - Load half @0x3 → err=1, rdata=0.
  - Store word 0x12345678 @0x2 → err=1, memory unchanged (a subsequent word load @0x0 returns its prior value).
  - Size 11 → err=1.
- Wrap-around: store word 0xA5A5A5A5 @0x1C, then load @0x3C → 0xA5A5A5A5 (upper address bits ignored).
- Pipelining, RD_LAT=3: back-to-back loads with tags 1, 2, 3 → resp_valid is high for three consecutive cycles starting 3 cycles after the first acceptance, with tags 1, 2, 3 in order.
- Reset asserted with 2 loads in flight (RD_LAT=3) → no response appears. Previously written data reads back 0 after re-initialisation.

Source files
------------

// File: rtl/lsu_data_mem.sv
// Byte-addressable little-endian data memory for the load/store unit.
// Self-clears one word per cycle after reset, then serves tagged requests with a fixed latency.
module lsu_data_mem #(
  parameter int DEPTH_BYTES = 32,
  parameter int RD_LAT      = 1,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_unsigned_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             resp_valid_o,
  output logic [31:0]      resp_rdata_o,
  output logic             resp_err_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             init_done_o
);

  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int CW    = AW - 2;
  localparam int WORDS = DEPTH_BYTES / 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    clr_cnt_q;
  logic             ready_q;
  logic [7:0]       mem_q [DEPTH_BYTES];

  logic             pipe_valid_q [RD_LAT];
  logic [31:0]      pipe_rdata_q [RD_LAT];
  logic             pipe_err_q   [RD_LAT];
  logic [TAG_W-1:0] pipe_tag_q   [RD_LAT];

  logic             accept_s;
  logic             err_s;
  logic             store_we_s;
  logic             clr_we_s;
  logic [AW-1:0]    base_addr_s;
  logic [AW-1:0]    lane_addr_s [4];
  logic [7:0]       rd_byte_s   [4];
  logic [3:0]       lane_en_s;
  logic [31:0]      load_data_s;
  logic [31:0]      resp_rdata_s;
  logic             unused_addr_s;

  // Upper address bits are intentionally dropped so accesses wrap within the array.
  assign unused_addr_s = ^req_addr_i[31:AW];

  // Request decode: alignment check, byte lanes and extended load data.
  always_comb begin
    accept_s    = req_valid_i & ready_q & ~reset;
    base_addr_s = req_addr_i[AW-1:0];
    for (int k = 0; k < 4; k++) begin
      lane_addr_s[k] = base_addr_s + AW'(k);
      rd_byte_s[k]   = mem_q[lane_addr_s[k]];
    end

    case (req_size_i)
      2'b00:   err_s = 1'b0;
      2'b01:   err_s = req_addr_i[0];
      2'b10:   err_s = (req_addr_i[1:0] != 2'b00);
      default: err_s = 1'b1;
    endcase

    case (req_size_i)
      2'b00:   lane_en_s = 4'b0001;
      2'b01:   lane_en_s = 4'b0011;
      2'b10:   lane_en_s = 4'b1111;
      default: lane_en_s = 4'b0000;
    endcase

    case (req_size_i)
      2'b00:   load_data_s = {{24{~req_unsigned_i & rd_byte_s[0][7]}}, rd_byte_s[0]};
      2'b01:   load_data_s = {{16{~req_unsigned_i & rd_byte_s[1][7]}}, rd_byte_s[1], rd_byte_s[0]};
      2'b10:   load_data_s = {rd_byte_s[3], rd_byte_s[2], rd_byte_s[1], rd_byte_s[0]};
      default: load_data_s = 32'h0000_0000;
    endcase

    if (accept_s && !req_we_i && !err_s) begin
      resp_rdata_s = load_data_s;
    end else begin
      resp_rdata_s = 32'h0000_0000;
    end

    store_we_s = accept_s & req_we_i & ~err_s;
    clr_we_s   = (state_q == ST_CLEAR) & ~reset;
  end

  // Storage array: clearing sweep has priority, it never overlaps with accepted stores.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      for (int k = 0; k < 4; k++) begin
        mem_q[{clr_cnt_q, k[1:0]}] <= 8'h00;
      end
    end else if (store_we_s) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en_s[k]) begin
          mem_q[lane_addr_s[k]] <= req_wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Init FSM: sweep every word to zero, then open for requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + CW'(1);
          if (clr_cnt_q == CW'(WORDS - 1)) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_cnt_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // Response delay line; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_rdata_q[i] <= 32'h0000_0000;
        pipe_err_q[i]   <= 1'b0;
        pipe_tag_q[i]   <= '0;
      end
    end else begin
      pipe_valid_q[0] <= accept_s;
      pipe_rdata_q[0] <= resp_rdata_s;
      pipe_err_q[0]   <= accept_s & err_s;
      pipe_tag_q[0]   <= accept_s ? req_tag_i : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_rdata_q[i] <= pipe_rdata_q[i-1];
        pipe_err_q[i]   <= pipe_err_q[i-1];
        pipe_tag_q[i]   <= pipe_tag_q[i-1];
      end
    end
  end

  assign req_ready_o  = ready_q;
  assign init_done_o  = ready_q;
  assign resp_valid_o = pipe_valid_q[RD_LAT-1];
  assign resp_rdata_o = pipe_rdata_q[RD_LAT-1];
  assign resp_err_o   = pipe_err_q[RD_LAT-1];
  assign resp_tag_o   = pipe_tag_q[RD_LAT-1];

endmodule

// File: tb/tb_lsu_data_mem.sv
// Bench for lsu_data_mem: directed scenarios plus random traffic, checked against a byte-array model.
module tb_lsu_data_mem;

  localparam int DEPTH  = 32;
  localparam int RD_LAT = 3;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic [31:0]      resp_rdata;
  logic             resp_err;
  logic [TAG_W-1:0] resp_tag;
  logic             init_done;

  always #5 clk = ~clk;

  lsu_data_mem #(.DEPTH_BYTES(DEPTH), .RD_LAT(RD_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_tag_i(req_tag),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .resp_tag_o(resp_tag), .init_done_o(init_done)
  );

  typedef struct { int due; logic [31:0] rdata; logic err; logic [TAG_W-1:0] tag; } exp_t;
  typedef struct { int cyc; logic [TAG_W-1:0] tag; } hist_t;

  exp_t             exp_q[$];
  hist_t            hist_q[$];
  logic [7:0]       mm [DEPTH];
  int               cyc = 0;
  int               n_vec = 0;
  int               n_bad = 0;
  int               clr_edges = 0;
  bit               model_ready = 1'b0;
  logic [31:0]      last_rdata;
  logic             last_err;
  logic [TAG_W-1:0] last_tag;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Reference: memory as a plain byte array, responses as a queue with due cycle.
  task automatic model_access(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] ad, input logic [31:0] wd, input logic [TAG_W-1:0] tg);
    exp_t e;
    int a, n;
    logic [31:0] v;
    a = int'(ad % 32'(DEPTH));
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    e.rdata = 32'd0;
    e.tag = tg;
    e.due = cyc + RD_LAT - 1;
    if (!e.err) begin
      if (we) begin
        for (int k = 0; k < n; k++) mm[(a + k) % DEPTH] = 8'(wd >> (8 * k));
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(mm[(a + k) % DEPTH]) << (8 * k));
        if (n == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
        if (n == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step();
    bit acc, rst;
    logic we, uns;
    logic [1:0] sz;
    logic [31:0] ad, wd;
    logic [TAG_W-1:0] tg;
    exp_t e;
    acc = req_valid && model_ready;
    rst = reset;
    we = req_we; sz = req_size; uns = req_unsigned; ad = req_addr; wd = req_wdata; tg = req_tag;
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      model_ready = 1'b0;
      clr_edges = 0;
    end else if (!model_ready) begin
      clr_edges++;
      if (clr_edges == DEPTH / 4) begin
        model_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
      end
    end else if (acc) begin
      model_access(we, sz, uns, ad, wd, tg);
    end
    @(negedge clk);
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_rdata", resp_rdata, e.rdata);
      check("resp_err", 32'(resp_err), 32'(e.err));
      check("resp_tag", 32'(resp_tag), 32'(e.tag));
    end else begin
      check("resp_idle", 32'(resp_valid), 32'd0);
    end
    check("req_ready", 32'(req_ready), 32'(model_ready));
    check("init_done", 32'(init_done), 32'(model_ready));
    if (resp_valid === 1'b1) begin
      hist_q.push_back('{cyc: cyc, tag: resp_tag});
      last_rdata = resp_rdata;
      last_err = resp_err;
      last_tag = resp_tag;
    end
  endtask

  task automatic op(input logic we, input logic [1:0] sz, input logic uns,
                    input logic [31:0] ad, input logic [31:0] wd, input logic [TAG_W-1:0] tg);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = ad; req_wdata = wd; req_tag = tg;
    req_valid = 1'b1;
    last_rdata = 'x; last_err = 1'bx; last_tag = 'x;
    step();
    req_valid = 1'b0;
    repeat (RD_LAT) step();
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check(name, 32'(n), 32'(DEPTH / 4));
  endtask

  initial begin
    int t0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_tag = '0;
    step();
    step();
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_tag", 32'(resp_tag), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    wait_ready("init_edges");

    op(1'b0, 2'd2, 1'b0, 32'h1C, 32'd0, 4'd0);
    check("ld_w_1c", last_rdata, 32'h0000_0000);
    check("ld_w_1c_err", 32'(last_err), 32'd0);
    op(1'b1, 2'd2, 1'b0, 32'h4, 32'hDEAD_BEEF, 4'd3);
    check("st_tag", 32'(last_tag), 32'd3);
    check("st_rdata", last_rdata, 32'd0);
    op(1'b0, 2'd0, 1'b0, 32'h5, 32'd0, 4'd4);
    check("ld_b_s", last_rdata, 32'hFFFF_FFBE);
    op(1'b0, 2'd0, 1'b1, 32'h5, 32'd0, 4'd5);
    check("ld_b_u", last_rdata, 32'h0000_00BE);
    op(1'b0, 2'd1, 1'b0, 32'h6, 32'd0, 4'd6);
    check("ld_h_s", last_rdata, 32'hFFFF_DEAD);
    op(1'b0, 2'd1, 1'b0, 32'h3, 32'd0, 4'd7);
    check("mis_h_err", 32'(last_err), 32'd1);
    check("mis_h_rdata", last_rdata, 32'd0);
    op(1'b1, 2'd2, 1'b0, 32'h0, 32'h1122_3344, 4'd8);
    op(1'b1, 2'd2, 1'b0, 32'h2, 32'h1234_5678, 4'd9);
    check("mis_w_err", 32'(last_err), 32'd1);
    op(1'b0, 2'd2, 1'b0, 32'h0, 32'd0, 4'd10);
    check("mis_w_nowrite", last_rdata, 32'h1122_3344);
    op(1'b0, 2'd3, 1'b0, 32'h8, 32'd0, 4'd11);
    check("size11_err", 32'(last_err), 32'd1);
    op(1'b1, 2'd2, 1'b0, 32'h1C, 32'hA5A5_A5A5, 4'd12);
    op(1'b0, 2'd2, 1'b0, 32'h3C, 32'd0, 4'd13);
    check("wrap", last_rdata, 32'hA5A5_A5A5);

    hist_q.delete();
    t0 = cyc + 1;
    for (int i = 1; i <= 3; i++) begin
      req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'(4 * i);
      req_tag = 4'(i); req_valid = 1'b1;
      step();
    end
    req_valid = 1'b0;
    repeat (RD_LAT + 1) step();
    check("pipe_cnt", 32'(hist_q.size()), 32'd3);
    if (hist_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("pipe_cyc", 32'(hist_q[i].cyc - t0), 32'(RD_LAT - 1 + i));
        check("pipe_tag", 32'(hist_q[i].tag), 32'(i + 1));
      end
    end

    hist_q.delete();
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h4; req_tag = 4'd1; req_valid = 1'b1;
    step();
    req_tag = 4'd2;
    step();
    req_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_ready("reinit_edges");
    check("flight_drop", 32'(hist_q.size()), 32'd0);
    op(1'b0, 2'd2, 1'b0, 32'h4, 32'd0, 4'd14);
    check("reinit_zero", last_rdata, 32'd0);

    for (int it = 0; it < 600; it++) begin
      reset = ($urandom_range(0, 149) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_we = 1'($urandom_range(0, 1));
      req_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      req_unsigned = 1'($urandom_range(0, 1));
      req_addr = $urandom;
      if ($urandom_range(0, 1) == 1) req_addr[1:0] = 2'b00;
      req_wdata = $urandom;
      req_tag = 4'($urandom_range(0, 15));
      step();
    end
    reset = 1'b0;
    req_valid = 1'b0;
    repeat (RD_LAT + 2) step();
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
